// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: FSM state encoding and digit-count helper for serial_subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int ndig(input int width, input int digit_w);
    return width / digit_w;
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: valid/ready operand and result bundle; ovf exists only with SERIAL_SUB_OVF_EN
interface serial_subtractor_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, bin, out_valid, out_ready, bor;
  logic [WIDTH-1:0] a, b, d;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
  modport master(output in_valid, a, b, bin, out_ready, input in_ready, out_valid, d, bor, ovf);
  modport slave(input in_valid, a, b, bin, out_ready, output in_ready, out_valid, d, bor, ovf);
`else
  modport master(output in_valid, a, b, bin, out_ready, input in_ready, out_valid, d, bor);
  modport slave(input in_valid, a, b, bin, out_ready, output in_ready, out_valid, d, bor);
`endif
endinterface

// File: rtl/digit_subtractor.sv
// digit_subtractor: combinational ripple-borrow subtractor for one digit; bmsb only with SERIAL_SUB_OVF_EN
module digit_subtractor #(parameter int DIGIT_W = 4) (
  input  logic [DIGIT_W-1:0] a_dig,
  input  logic [DIGIT_W-1:0] b_dig,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d_dig,
  output logic               bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic               bmsb
`endif
);
  logic [DIGIT_W:0] c;
  assign c[0] = bin;
  for (genvar i = 0; i < DIGIT_W; i++) begin : g_bit
    assign d_dig[i] = a_dig[i] ^ b_dig[i] ^ c[i];
    assign c[i+1]   = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & c[i]);
  end
  assign bout = c[DIGIT_W];
`ifdef SERIAL_SUB_OVF_EN
  assign bmsb = c[DIGIT_W-1];
`endif
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: a - b - bin over WIDTH bits, DIGIT_W bits per clock, LSB digit first.
// Signed overflow output is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 4
) (
  input logic clk,
  input logic rst_n,
  serial_subtractor_if.slave bus
);
  localparam int NDIG = ndig(WIDTH, DIGIT_W);
  localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH % DIGIT_W != 0) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT_W");
  end
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next, d_r;
  logic [DIGIT_W-1:0] d_dig;
  logic brw, bout, bor_r, last;
  assign last   = cnt == CW'(NDIG - 1);
  // new digit enters at the top so the LSB digit lands at bit 0 after NDIG shifts
  assign r_next = (r_sh >> DIGIT_W) | (WIDTH'(d_dig) << (WIDTH - DIGIT_W));
`ifdef SERIAL_SUB_OVF_EN
  logic bmsb, ovf_r;
  digit_subtractor #(.DIGIT_W(DIGIT_W)) u_dig (
    .a_dig(a_sh[DIGIT_W-1:0]), .b_dig(b_sh[DIGIT_W-1:0]), .bin(brw),
    .d_dig(d_dig), .bout(bout), .bmsb(bmsb)
  );
  assign bus.ovf = ovf_r;
`else
  digit_subtractor #(.DIGIT_W(DIGIT_W)) u_dig (
    .a_dig(a_sh[DIGIT_W-1:0]), .b_dig(b_sh[DIGIT_W-1:0]), .bin(brw),
    .d_dig(d_dig), .bout(bout)
  );
`endif
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.d         = d_r;
  assign bus.bor       = bor_r;
  always_comb begin
    nxt = state;
    if (state == IDLE && bus.in_valid) nxt = RUN;
    if (state == RUN && last) nxt = DONE;
    if (state == DONE && bus.out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      brw   <= 1'b0;
      d_r   <= '0;
      bor_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_r <= 1'b0;
`endif
    end else if (state == IDLE && bus.in_valid) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      brw  <= bus.bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT_W;
      b_sh <= b_sh >> DIGIT_W;
      r_sh <= r_next;
      brw  <= bout;
      cnt  <= cnt + CW'(1);
      if (last) begin
        d_r   <= r_next;
        bor_r <= bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf_r <= bmsb ^ bout;
`endif
      end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random operations checked against an integer-arithmetic model.
// ovf is checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;
  localparam int WIDTH = 8, DIGIT_W = 4, NDIG = WIDTH / DIGIT_W;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0;
  serial_subtractor_if #(.WIDTH(WIDTH)) bus();
  serial_subtractor #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                       output logic [WIDTH-1:0] d, output logic bor, output logic ovf);
    longint ua, ub, sa, sb, r, half;
    ua   = longint'(a);
    ub   = longint'(b);
    half = longint'(1) << (WIDTH - 1);
    d    = WIDTH'(ua - ub - longint'(bin));
    bor  = ua < ub + longint'(bin);
    sa   = a[WIDTH-1] ? ua - 2 * half : ua;
    sb   = b[WIDTH-1] ? ub - 2 * half : ub;
    r    = sa - sb - longint'(bin);
    ovf  = r < -half || r >= half;
  endtask
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin, input int hold);
    logic [WIDTH-1:0] ed;
    logic eb, eo;
    int lat;
    model(a, b, bin, ed, eb, eo);
    check("idle_in_ready", 64'(bus.in_ready), 64'(1));
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.bin       = bin;
    bus.out_ready = hold == 0;
    step();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.a        = WIDTH'($urandom);
    check("run_in_ready", 64'(bus.in_ready), 64'(0));
    lat = 0;
    while (!bus.out_valid && lat < 4 * NDIG + 8) begin
      step();
      lat++;
    end
    check("latency", 64'(lat), 64'(NDIG));
    check("d", 64'(bus.d), 64'(ed));
    check("bor", 64'(bus.bor), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 64'(bus.ovf), 64'(eo));
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      bus.bin      = 1'($urandom);
      step();
      check("hold_d", 64'(bus.d), 64'(ed));
      check("hold_bor", 64'(bus.bor), 64'(eb));
      check("hold_in_ready", 64'(bus.in_ready), 64'(0));
      check("hold_out_valid", 64'(bus.out_valid), 64'(1));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("back_in_ready", 64'(bus.in_ready), 64'(1));
    check("back_out_valid", 64'(bus.out_valid), 64'(0));
    check("idle_d_held", 64'(bus.d), 64'(ed));
  endtask
  initial begin
    logic seen;
    int prev;
    logic [WIDTH-1:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    repeat (2) step();
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_d", 64'(bus.d), 64'(0));
    check("rst_bor", 64'(bus.bor), 64'(0));
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 64'(bus.ovf), 64'(0));
`endif
    rst_n = 1'b1;
    step();
    run_op(WIDTH'(8'h05), WIDTH'(8'h03), 1'b0, 0);
    run_op(WIDTH'(8'h00), WIDTH'(8'h01), 1'b0, 1);
    run_op(WIDTH'(8'h10), WIDTH'(8'h0F), 1'b1, 0);
    run_op(WIDTH'(8'h80), WIDTH'(8'h01), 1'b0, 0);
    run_op(WIDTH'(8'h7F), WIDTH'(8'hFF), 1'b0, 0);
    run_op(WIDTH'(8'h05), WIDTH'(8'h03), 1'b0, 5);
    run_op(WIDTH'(8'h00), WIDTH'(8'h01), 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      prev = acc_cyc;
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0);
      check("throughput", 64'(acc_cyc - prev), 64'(NDIG + 2));
    end
    run_op(WIDTH'(8'hFF), WIDTH'(8'h00), 1'b0, 0);
    // abort: reset lands while the operation is still in RUN
    bus.in_valid = 1'b1;
    bus.a        = WIDTH'(8'h33);
    bus.b        = WIDTH'(8'h11);
    bus.bin      = 1'b0;
    step();
    bus.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("abort_d", 64'(bus.d), 64'(0));
    check("abort_bor", 64'(bus.bor), 64'(0));
    check("abort_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    repeat (2) step();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < NDIG + 3; i++) begin
      step();
      seen |= bus.out_valid;
    end
    check("abort_no_result", 64'(seen), 64'(0));
    for (int i = 0; i < 150; i++) begin
      ra = $urandom_range(0, 3) == 0 ? (1'($urandom) ? '1 : '0) : WIDTH'($urandom);
      rb = $urandom_range(0, 3) == 0 ? (1'($urandom) ? '1 : '0) : WIDTH'($urandom);
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor that computes `a - b - bin` over WIDTH bits, DIGIT_W bits per clock. The borrow is registered between digits. It is the sequential, wide successor to the single-bit full subtractor cell. It sits between a valid/ready producer and consumer in the arithmetic datapath, trading latency for small area on wide operands.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Must be a multiple of DIGIT_W.
- DIGIT_W, 4: bits processed per cycle. NDIG = WIDTH/DIGIT_W digits per operation.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- d  output  WIDTH  difference.
- bor  output  1  borrow out of MSB.
- ovf  output  1  signed overflow. Present only with SERIAL_SUB_OVF_EN.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b and bin into operand shift registers, clear digit counter, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, one digit (LSB digit first) is subtracted with the registered borrow.
  - The result digit is shifted into the result register and the borrow register is updated.
  - When the counter reaches NDIG-1: copy result to d and final borrow to bor, go to DONE.
- DONE:
  - out_valid = 1.
  - d, bor and ovf are held stable.
  - On out_ready: go to IDLE.
- Arithmetic:
  - d = (a - b - bin) mod 2^WIDTH.
  - bor = 1 iff a < b + bin (unsigned compare at WIDTH+1 bits).
- d, bor and ovf change only on entry to DONE. They hold their last values in IDLE and RUN.
- in_valid in RUN or DONE is ignored. Operands are not re-sampled.
- The output transfer and the next input acceptance never occur in the same cycle.

## Timing
- Reset values: state IDLE; in_ready 1; out_valid 0; d 0; bor 0; ovf 0; counter and borrow register 0.
- Reset mid-operation (rst_n low in RUN or DONE) aborts the operation immediately. No result is emitted.
- Latency: input accepted at edge T; out_valid rises after edge T+NDIG.
- Back-to-back throughput is NDIG+2 cycles per operation with out_ready held high.
- NDIG = 1 (WIDTH == DIGIT_W) is legal: RUN lasts one cycle.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready.

## Configuration
- SERIAL_SUB_OVF_EN is defined:
  - Port ovf exists.
  - ovf = (borrow into MSB) XOR (borrow out of MSB), captured on entry to DONE.
- SERIAL_SUB_OVF_EN is undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package serial_sub_pkg holds the FSM state enum (IDLE, RUN, DONE) and a localparam helper for NDIG.
- Sub-module digit_subtractor: combinational DIGIT_W-bit ripple-borrow subtractor.
  - Inputs: a_dig, b_dig, bin.
  - Outputs: d_dig, bout, and the borrow into its top bit (bmsb) for overflow.
- A generate-time assertion checks that WIDTH % DIGIT_W == 0.

## Test plan
All scenarios use WIDTH=8, DIGIT_W=4 unless stated.
- a=0x05, b=0x03, bin=0 -> d=0x02, bor=0; out_valid exactly 2 cycles after acceptance.
- a=0x00, b=0x01, bin=0 -> d=0xFF, bor=1.
- a=0x10, b=0x0F, bin=1 -> d=0x00, bor=0 (borrow propagates across the digit boundary).
- Hold out_ready=0 for 5 cycles after out_valid, toggling in_valid with new operands:
  - d and bor stay stable; in_ready stays 0; new operands are ignored.
  - Raising out_ready gives IDLE and in_ready=1 the next cycle.
- Assert rst_n low during RUN -> outputs 0 immediately, state IDLE, no out_valid pulse.
- With SERIAL_SUB_OVF_EN:
  - 0x80-0x01 -> d=0x7F, ovf=1.
  - 0x7F-0xFF -> d=0x80, ovf=1.
  - 0x05-0x03 -> ovf=0.
- Repeat with WIDTH=DIGIT_W=8 -> 1-cycle RUN.
- Repeat with WIDTH=32, DIGIT_W=1, random vectors checked against the reference `a - b - bin`.
